// File: rtl/spi_link_pkg.sv
// spi_link_pkg: FSM states and command/header codes for the SPI link master.
// Shared by the PHY and the data-sequencing FSM.
package spi_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    TX_CMD,
    HUNT,
    STREAM,
    STOP
  } state_e;

  localparam logic [7:0] VIDEO_CMD = 8'hFA;
  localparam logic [7:0] AUDIO_CMD = 8'hAA;
  localparam logic [7:0] VIDEO_HDR = 8'h5A;
  localparam logic [7:0] AUDIO_HDR = 8'hA5;

endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: 8-bit MSB-first shift register with a 3-bit bit counter.
// Shared between command transmit and payload receive.
module spi_shift_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       shift_en,
  input  logic       bit_in,
  output logic       msb,
  output logic       nxt_msb,
  output logic [7:0] byte_nxt,
  output logic       byte_done
);

  logic [7:0] data_q, data_d;
  logic [2:0] cnt_q, cnt_d;

  assign msb       = data_q[7];
  assign nxt_msb   = data_q[6];
  assign byte_nxt  = {data_q[6:0], bit_in};
  assign byte_done = shift_en & (cnt_q == 3'd7);

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load) begin
      data_d = load_val;
      cnt_d  = 3'd0;
    end else if (shift_en) begin
      data_d = byte_nxt;
      cnt_d  = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= 8'h00;
      cnt_q  <= 3'd0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_link_master.sv
// spi_link_master: mode-0 SPI master framing command, header hunt and stream.
// Optional header-hunt timeout enabled by defining SPI_HDR_TIMEOUT_EN.
module spi_link_master
  import spi_link_pkg::*;
#(
  parameter logic        CPOL_IDLE        = 1'b0,
  parameter int unsigned MAX_SEARCH_BYTES = 1024,
  parameter int unsigned SEARCH_CNT_W     = 11
) (
  input  logic       CLK_40,
  input  logic       reset,
  input  logic       SPI_clk_en,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  input  logic [7:0] hdr_byte,
  output logic       cmd_ready,
  output logic       cmd_done,
  output logic       header_found,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_stop,
  output logic       search_timeout,
  output logic       busy,
  input  logic       MISO,
  output logic       MOSI,
  output logic       SCLK,
  output logic       chip_select
);

  state_e     state_q, state_d;
  logic       cs_q, cs_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       done_q, done_d;
  logic       hfnd_q, hfnd_d;
  logic       rxv_q, rxv_d;
  logic       tmo_q, tmo_d;
  logic [7:0] rxd_q, rxd_d;
  logic [7:0] hdr_q, hdr_d;

  logic       accept, tx_fall, rx_rise;
  logic       sr_load, sr_shift, sr_msb, sr_nxt, sr_done;
  logic [7:0] sr_val, sr_byte;

  assign accept  = (state_q == IDLE) & cmd_valid;
  assign tx_fall = (state_q == TX_CMD) & SPI_clk_en & sclk_q;
  assign rx_rise = ((state_q == HUNT) | (state_q == STREAM))
                 & SPI_clk_en & ~sclk_q;

  assign sr_shift = tx_fall | rx_rise;
  // End of command reuses the register for receive, realigning the counter.
  assign sr_load  = accept | (tx_fall & sr_done);
  assign sr_val   = accept ? cmd_byte : 8'h00;

  spi_shift_reg u_sr (
    .clk       (CLK_40),
    .reset     (reset),
    .load      (sr_load),
    .load_val  (sr_val),
    .shift_en  (sr_shift),
    .bit_in    (MISO),
    .msb       (sr_msb),
    .nxt_msb   (sr_nxt),
    .byte_nxt  (sr_byte),
    .byte_done (sr_done)
  );

`ifdef SPI_HDR_TIMEOUT_EN
  logic [SEARCH_CNT_W-1:0] srch_q, srch_d;
  localparam logic [SEARCH_CNT_W-1:0] SRCH_LAST =
    SEARCH_CNT_W'(MAX_SEARCH_BYTES - 1);
`else
  logic [SEARCH_CNT_W-1:0] unused_lim;
  assign unused_lim = SEARCH_CNT_W'(MAX_SEARCH_BYTES);
`endif

  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    hdr_d   = hdr_q;
    rxd_d   = rxd_q;
    done_d  = 1'b0;
    hfnd_d  = 1'b0;
    rxv_d   = 1'b0;
    tmo_d   = 1'b0;
`ifdef SPI_HDR_TIMEOUT_EN
    srch_d  = srch_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          hdr_d   = hdr_byte;
          state_d = START;
        end
      end
      START: begin
        if (SPI_clk_en) begin
          cs_d    = 1'b0;
          sclk_d  = CPOL_IDLE;
          mosi_d  = sr_msb;
          state_d = TX_CMD;
        end
      end
      TX_CMD: begin
        if (SPI_clk_en) sclk_d = ~sclk_q;
        if (tx_fall) begin
          if (sr_done) begin
            done_d  = 1'b1;
            mosi_d  = 1'b0;
            state_d = HUNT;
`ifdef SPI_HDR_TIMEOUT_EN
            srch_d  = '0;
`endif
          end else begin
            mosi_d = sr_nxt;
          end
        end
      end
      HUNT, STREAM: begin
        if (SPI_clk_en) sclk_d = ~sclk_q;
        if (sr_done) begin
          if (state_q == STREAM) begin
            rxd_d = sr_byte;
            rxv_d = 1'b1;
          end else if (sr_byte == hdr_q) begin
            hfnd_d  = 1'b1;
            state_d = STREAM;
          end else begin
`ifdef SPI_HDR_TIMEOUT_EN
            srch_d = srch_q + 1'b1;
            if (srch_q == SRCH_LAST) begin
              tmo_d   = 1'b1;
              state_d = STOP;
            end
`endif
          end
        end
        // A byte finishing on the stop cycle is still delivered above.
        if (rx_stop) state_d = STOP;
      end
      STOP: begin
        if (SPI_clk_en) begin
          if (sclk_q) begin
            sclk_d = CPOL_IDLE;
          end else begin
            cs_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_40) begin
    if (reset) begin
      state_q <= IDLE;
      cs_q    <= 1'b1;
      sclk_q  <= CPOL_IDLE;
      mosi_q  <= 1'b0;
      hdr_q   <= 8'h00;
      rxd_q   <= 8'h00;
      done_q  <= 1'b0;
      hfnd_q  <= 1'b0;
      rxv_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      hdr_q   <= hdr_d;
      rxd_q   <= rxd_d;
      done_q  <= done_d;
      hfnd_q  <= hfnd_d;
      rxv_q   <= rxv_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef SPI_HDR_TIMEOUT_EN
  always_ff @(posedge CLK_40) begin
    if (reset) srch_q <= '0;
    else       srch_q <= srch_d;
  end
`endif

  assign cmd_ready      = (state_q == IDLE);
  assign busy           = ~cs_q;
  assign chip_select    = cs_q;
  assign SCLK           = sclk_q;
  assign MOSI           = mosi_q;
  assign cmd_done       = done_q;
  assign header_found   = hfnd_q;
  assign rx_valid       = rxv_q;
  assign rx_data        = rxd_q;
  assign search_timeout = tmo_q;

endmodule

// File: tb/tb_spi_link_master.sv
// tb_spi_link_master: directed and randomized transactions against a slave
// model and a byte-level reference of the expected link events.
module tb_spi_link_master;
  import spi_link_pkg::*;

`ifdef SPI_HDR_TIMEOUT_EN
  localparam int MAXB = 4;
`else
  localparam int MAXB = 1024;
`endif

  logic       CLK_40 = 1'b0;
  logic       reset, cmd_valid, rx_stop, MISO;
  logic [7:0] cmd_byte, hdr_byte;
  logic       cmd_ready, cmd_done, header_found, rx_valid;
  logic       search_timeout, busy, MOSI, SCLK, chip_select;
  logic [7:0] rx_data;
  logic       SPI_clk_en;

  int n_run = 0;
  int n_fail = 0;

  int period = 4;
  int tcnt = 0;

  spi_link_master #(.MAX_SEARCH_BYTES(MAXB)) dut (
    .CLK_40(CLK_40), .reset(reset), .SPI_clk_en(SPI_clk_en),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .hdr_byte(hdr_byte),
    .cmd_ready(cmd_ready), .cmd_done(cmd_done),
    .header_found(header_found), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_stop(rx_stop),
    .search_timeout(search_timeout), .busy(busy), .MISO(MISO),
    .MOSI(MOSI), .SCLK(SCLK), .chip_select(chip_select)
  );

  always #5 CLK_40 = ~CLK_40;

  always @(posedge CLK_40) tcnt <= (tcnt >= period - 1) ? 0 : tcnt + 1;
  assign SPI_clk_en = (tcnt == period - 1);

  // Slave model: bit n of the stream is presented for the n-th SCLK rise.
  logic       slave_bits[$];
  logic [7:0] mosi_seen[$];
  logic       mosi_bits[$];
  int         rise_n = 0;

  function automatic logic bitat(int n);
    if (n < slave_bits.size()) return slave_bits[n];
    return 1'b0;
  endfunction

  always @(posedge chip_select or posedge SCLK) begin
    if (chip_select) rise_n = 0;
    else begin
      mosi_bits.push_back(MOSI);
      rise_n = rise_n + 1;
    end
  end

  always @(negedge chip_select or negedge SCLK) MISO = bitat(rise_n);

  // Event monitor, sampled mid-cycle.
  logic [7:0] rx_q[$];
  int cyc = 0, n_done = 0, n_hdr = 0, n_to = 0, n_multi = 0;
  int n_acc = 0, n_acc_busy = 0, n_sclk_bad = 0;
  int fall_cyc = 0, done_cyc = 0;
  logic cs_prev = 1'b1;

  always @(negedge CLK_40) begin
    cyc = cyc + 1;
    if (cmd_done) begin n_done++; done_cyc = cyc; end
    if (header_found) n_hdr++;
    if (rx_valid) rx_q.push_back(rx_data);
    if (search_timeout) n_to++;
    if (int'(cmd_done) + int'(header_found) + int'(rx_valid)
        + int'(search_timeout) > 1) n_multi++;
    if (cmd_valid && cmd_ready) begin
      n_acc++;
      if (!chip_select) n_acc_busy++;
    end
    if (cs_prev && !chip_select) fall_cyc = cyc;
    if (!cs_prev && chip_select && SCLK) n_sclk_bad++;
    cs_prev = chip_select;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK_40);
    #1;
  endtask

  task automatic wait_cs(input logic lvl, input int budget,
                         input string tag);
    int k = 0;
    while (chip_select !== lvl && k < budget) begin cycles(1); k++; end
    chk(tag, chip_select, lvl);
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin cycles(1); k++; end
    chk(tag, rx_q.size(), n);
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (n_done < n && k < budget) begin cycles(1); k++; end
    chk("done_wait", n_done, n);
  endtask

  task automatic load_slave(input logic [7:0] b[$]);
    slave_bits.delete();
    for (int i = 0; i < 8; i++) slave_bits.push_back(1'($urandom));
    foreach (b[i])
      for (int k = 7; k >= 0; k--) slave_bits.push_back(b[i][k]);
  endtask

  task automatic clear_mon();
    rx_q.delete(); mosi_bits.delete();
    n_done = 0; n_hdr = 0; n_to = 0; n_multi = 0; n_sclk_bad = 0;
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] h);
    clear_mon();
    cmd_byte = c; hdr_byte = h; cmd_valid = 1'b1;
    cycles(1);
    cmd_valid = 1'b0;
    chk("ready_drop", cmd_ready, 1'b0);
  endtask

  task automatic pulse_stop();
    rx_stop = 1'b1;
    cycles(1);
    rx_stop = 1'b0;
  endtask

  function automatic logic [7:0] mosi_cmd();
    logic [7:0] v = 8'h00;
    for (int i = 0; i < 8 && i < mosi_bits.size(); i++)
      v[7-i] = mosi_bits[i];
    return v;
  endfunction

  task automatic check_payload(input logic [7:0] exp[$]);
    chk("rx_count", rx_q.size(), exp.size());
    foreach (exp[i])
      if (i < rx_q.size()) chk("rx_byte", rx_q[i], exp[i]);
  endtask

  initial begin
    logic [7:0] bytes[$];
    logic [7:0] expq[$];
    int ones;
    int base;

    reset = 1'b1; cmd_valid = 1'b0; rx_stop = 1'b0; MISO = 1'b0;
    cmd_byte = 8'h00; hdr_byte = 8'h00;
    cycles(3);
    chk("rst_cs", chip_select, 1'b1);
    chk("rst_sclk", SCLK, 1'b0);
    chk("rst_mosi", MOSI, 1'b0);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rxd", rx_data, 8'h00);
    chk("rst_pulses", {cmd_done, header_found, rx_valid, search_timeout},
        4'b0000);
    reset = 1'b0;
    cycles(2);

    // Directed: video command, header hunt, two payload bytes, mid-byte stop.
    period = 4;
    bytes = '{8'h00, 8'h00, 8'h5A, 8'h11, 8'h22, 8'h33, 8'h44};
    load_slave(bytes);
    send(VIDEO_CMD, 8'h5A);
    wait_cs(1'b0, 20, "cs_fall");
    wait_rx(2, 2000, "dir_rx_wait");
    cycles(30);
    pulse_stop();
    wait_cs(1'b1, 100, "dir_cs_rise");
    chk("dir_mosi", mosi_cmd(), 8'hFA);
    chk("dir_done_cnt", n_done, 1);
    chk("dir_done_lat", done_cyc - fall_cyc, 64);
    chk("dir_hdr_cnt", n_hdr, 1);
    expq = '{8'h11, 8'h22};
    check_payload(expq);
    ones = 0;
    for (int i = 8; i < mosi_bits.size(); i++) ones += int'(mosi_bits[i]);
    chk("dir_mosi_idle", ones, 0);
    chk("dir_sclk_low", n_sclk_bad, 0);
    chk("dir_ready", cmd_ready, 1'b1);
    chk("dir_busy", busy, 1'b0);

    // Randomized transactions against the byte-level reference.
    for (int t = 0; t < 6; t++) begin
      logic [7:0] c, h, b;
      int npre, npay;
      period = int'($urandom_range(1, 4));
      cycles(5);
      case ($urandom_range(0, 2))
        0: c = VIDEO_CMD;
        1: c = AUDIO_CMD;
        default: c = 8'($urandom);
      endcase
      h = 8'($urandom);
      npre = int'($urandom_range(0, 3));
      npay = int'($urandom_range(1, 4));
      bytes.delete(); expq.delete();
      for (int i = 0; i < npre; i++) begin
        b = 8'($urandom);
        bytes.push_back((b == h) ? ~h : b);
      end
      bytes.push_back(h);
      for (int i = 0; i < npay; i++) begin
        b = 8'($urandom);
        bytes.push_back(b);
        expq.push_back(b);
      end
      for (int i = 0; i < 3; i++) bytes.push_back(8'($urandom));
      load_slave(bytes);
      send(c, h);
      wait_cs(1'b0, 20, "rnd_cs_fall");
      wait_rx(npay, 4000, "rnd_rx_wait");
      cycles(int'($urandom_range(1, 12 * period)));
      pulse_stop();
      wait_cs(1'b1, 100, "rnd_cs_rise");
      chk("rnd_mosi", mosi_cmd(), c);
      chk("rnd_done_cnt", n_done, 1);
      chk("rnd_done_lat", done_cyc - fall_cyc, 16 * period);
      chk("rnd_hdr_cnt", n_hdr, 1);
      check_payload(expq);
      chk("rnd_exclusive", n_multi, 0);
      chk("rnd_sclk_low", n_sclk_bad, 0);
    end

    // Reset in the middle of the command phase, then a clean transaction.
    period = 4;
    cycles(5);
    bytes = '{8'hC3, 8'h7E, 8'h00};
    load_slave(bytes);
    send(AUDIO_CMD, 8'hC3);
    wait_cs(1'b0, 20, "rst_mid_fall");
    cycles(26);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    chk("rmid_cs", chip_select, 1'b1);
    chk("rmid_sclk", SCLK, 1'b0);
    chk("rmid_mosi", MOSI, 1'b0);
    chk("rmid_ready", cmd_ready, 1'b1);
    cycles(80);
    chk("rmid_no_done", n_done, 0);
    load_slave(bytes);
    send(AUDIO_CMD, 8'hC3);
    wait_rx(1, 2000, "rmid_rx_wait");
    pulse_stop();
    wait_cs(1'b1, 100, "rmid_cs_rise");
    chk("rmid_mosi2", mosi_cmd(), AUDIO_CMD);
    chk("rmid_done2", n_done, 1);
    chk("rmid_rx", rx_q.size() > 0 ? rx_q[0] : 8'hxx, 8'h7E);

    // Header never appears: timeout with the macro, endless hunt without.
    period = 2;
    cycles(5);
    bytes = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load_slave(bytes);
    send(8'hFA, 8'h5A);
    wait_cs(1'b0, 20, "hunt_cs_fall");
`ifdef SPI_HDR_TIMEOUT_EN
    wait_cs(1'b1, 600, "to_cs_rise");
    chk("to_cnt", n_to, 1);
    chk("to_no_hdr", n_hdr, 0);
    chk("to_done_lat", (n_to == 1) ? 1 : 0, 1);
    chk("to_ready", cmd_ready, 1'b1);
`else
    cycles(240);
    chk("hunt_busy", busy, 1'b1);
    chk("hunt_no_hdr", n_hdr, 0);
    chk("hunt_no_to", n_to, 0);
    pulse_stop();
    wait_cs(1'b1, 100, "hunt_cs_rise");
    chk("hunt_ready", cmd_ready, 1'b1);
`endif

    // cmd_valid held high: one accept per IDLE visit.
    period = 1;
    cycles(3);
    bytes = '{8'h5A, 8'h01, 8'h02, 8'h03};
    load_slave(bytes);
    clear_mon();
    base = n_acc;
    cmd_byte = VIDEO_CMD; hdr_byte = 8'h5A; cmd_valid = 1'b1;
    wait_rx(1, 500, "hold_rx_wait");
    chk("hold_acc1", n_acc - base, 1);
    pulse_stop();
    wait_cs(1'b1, 50, "hold_cs_rise");
    cycles(2);
    chk("hold_acc2", n_acc - base, 2);
    chk("hold_acc_busy", n_acc_busy, 0);
    cmd_valid = 1'b0;
    wait_done(2, 200);
    pulse_stop();
    wait_cs(1'b1, 50, "hold_cs_end");
    chk("hold_acc_final", n_acc - base, 2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_link_master.md
Name: spi_link_master

Overview:
SPI master PHY that the data-sequencing FSM drives. It frames one transaction per request: assert chip select, shift out an 8-bit command, hunt byte-aligned for a header byte on MISO, then stream payload bytes to the video/audio buffer writers until told to stop. It supplies the FSM's "request sent" and "header parsed" events. All SPI activity advances only on SPI_clk_en ticks.

Parameters:
CPOL_IDLE, 1'b0, SCLK idle level (mode 0 only; fixed, exposed for assertion checks)
MAX_SEARCH_BYTES, 1024, header-hunt byte limit (used only with SPI_HDR_TIMEOUT_EN)
SEARCH_CNT_W, 11, width of search byte counter, ≥ clog2(MAX_SEARCH_BYTES+1)

Ports:
CLK_40  in  1  system clock, 40 MHz
reset  in  1  synchronous, active-high
SPI_clk_en  in  1  tick; one SCLK half-period per tick
cmd_valid  in  1  request a transaction
cmd_byte  in  8  command to send (e.g. 8'hFA video, 8'hAA audio)
hdr_byte  in  8  header byte to hunt for; latched with cmd_byte
cmd_ready  out  1  high in IDLE only
cmd_done  out  1  1-cycle pulse: last command bit shifted
header_found  out  1  1-cycle pulse: received byte == latched header
rx_data  out  8  payload byte, valid with rx_valid
rx_valid  out  1  1-cycle pulse per payload byte
rx_stop  in  1  end streaming (bank full)
search_timeout  out  1  1-cycle pulse on hunt abort (0 without macro)
busy  out  1  high whenever chip_select low
MISO  in  1  serial data from slave
MOSI  out  1  serial data to slave
SCLK  out  1  SPI clock
chip_select  out  1  active-low slave select

Behaviour:
- Reset (any state, mid-byte included): state IDLE, chip_select=1, SCLK=0, MOSI=0, all pulses 0, rx_data=0, cmd_ready=1, busy=0, counters cleared. Partial transactions are dropped; no pulse is emitted.
- Handshake: a command is accepted on a CLK_40 cycle with cmd_valid & cmd_ready, independent of SPI_clk_en. cmd_byte/hdr_byte are latched. cmd_ready drops the next cycle.
- SPI mode 0, MSB first. Each tick toggles SCLK while active. A rising-edge tick samples MISO. A falling-edge tick shifts the next MOSI bit. All outputs are registered.
- States:
  IDLE: on accept -> START.
  START: next tick: chip_select=0, MOSI=cmd[7], SCLK=0 -> TX_CMD.
  TX_CMD: 16 ticks (8 rise/fall pairs). On the 16th tick (final falling edge) pulse cmd_done, MOSI=0 -> HUNT.
  HUNT: MOSI held 0. After each 8th rising-edge sample, compare the assembled byte with hdr_byte. On match, pulse header_found -> STREAM. A header byte is never output on rx_data.
  STREAM: each completed byte updates rx_data and pulses rx_valid on the same cycle.
  STOP: SCLK driven low if high (one tick). Next tick chip_select=1 -> IDLE.
- rx_stop is sampled every CLK_40 cycle in STREAM or HUNT. When high, the block enters STOP immediately. The partial byte is discarded and no further rx_valid is emitted. A byte completing in the same cycle that rx_stop rises IS delivered.
- The pulses (cmd_done, header_found, rx_valid, search_timeout) occur only on tick cycles and are mutually exclusive.
- Bit counter is 3 bits and wraps; byte alignment is fixed from the first HUNT rising edge.
- rx_stop in IDLE/START/TX_CMD is ignored.

Optional Feature:
SPI_HDR_TIMEOUT_EN:
- Defined: HUNT counts compared bytes. If MAX_SEARCH_BYTES bytes are compared without a match, pulse search_timeout on that byte's compare cycle -> STOP.
- Undefined: HUNT waits indefinitely, search_timeout tied 0, and the counter is not built.

Decomposition:
- Package spi_link_pkg: state enum (IDLE, START, TX_CMD, HUNT, STREAM, STOP), command constants VIDEO_CMD=8'hFA and AUDIO_CMD=8'hAA, default header constants. The FSM imports the same package.
- One sub-module, spi_shift_reg: 8-bit shift register with load, shift-out MSB, shift-in on sample, and byte-complete flag. It is used for both TX and RX.

Test Plan:
- Reset, then send cmd 8'hFA with SPI_clk_en every 4th cycle → MOSI bits 1,1,1,1,1,0,1,0 on falling edges; cmd_done exactly once, 64 CLK_40 cycles after chip_select falls.
- Slave sends 00,00,5A,11,22 with hdr 8'h5A → header_found once after the 3rd byte; rx_valid twice with 8'h11 then 8'h22; 8'h5A never appears on rx_data.
- rx_stop rises mid-byte (bit 4) → no further rx_valid; SCLK=0 before chip_select rises; cmd_ready=1 in IDLE.
- reset asserted during TX_CMD bit 3 → next cycle chip_select=1, SCLK=0, no cmd_done; a new command completes normally.
- With SPI_HDR_TIMEOUT_EN and MAX_SEARCH_BYTES=4, send 00 ×6 → search_timeout after the 4th byte, no header_found, chip_select high; without the macro → still in HUNT after 6 bytes.
- cmd_valid held high through a transaction → exactly one accept per IDLE visit; the second transaction starts only after chip_select returns high.
